cfg_seq: RTL

- Parametrised camera-configuration sequencer. Walks a register table held in an external synchronous ROM (1-cycle read delay) and issues one register write per entry to the SCCB/I2C master over a valid/ready + done/nack handshake.
- Supports multiple table profiles, timed delay entries, an end marker, NACK retry with an error report, and completion/progress status.
- Sits between the configuration ROM and the SCCB master in the camera front end.

---
 rtl/cfg_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cfg_seq.sv
// cfg_seq: camera configuration sequencer.
// Walks a {reg, data} table in a synchronous ROM and issues one register write
// per entry to the SCCB master. It handles delay entries, the end marker,
// NACK retry and an error report.
module cfg_seq #(
  parameter int REG_W      = 8,
  parameter int IDX_W      = 8,
  parameter int PROF_W     = 1,
  parameter int DELAY_UNIT = 100000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [PROF_W-1:0]       i_profile,
  output logic [PROF_W+IDX_W-1:0] o_rom_addr,
  input  logic [2*REG_W-1:0]      i_rom_data,
  output logic                    o_wr_valid,
  output logic [REG_W-1:0]        o_wr_reg,
  output logic [REG_W-1:0]        o_wr_data,
  input  logic                    i_wr_ready,
  input  logic                    i_wr_done,
  input  logic                    i_wr_nack,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [IDX_W-1:0]        o_err_idx,
  output logic [IDX_W:0]          o_count
);

  // The delay counter holds data*DELAY_UNIT. That product always fits in
  // REG_W + clog2(DELAY_UNIT) bits.
  localparam int CW = REG_W + $clog2(DELAY_UNIT);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [REG_W-1:0] MARK      = '1;
  localparam logic [CW-1:0]    DU_C      = CW'(DELAY_UNIT);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ROM_WAIT,
    S_DECODE,
    S_REQ,
    S_ACK,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic [PROF_W-1:0]         prof_q;
  logic [IDX_W-1:0]          idx_q;
  logic [RW-1:0]             retry_q;
  logic [CW-1:0]             dly_q;
  logic [PROF_W+IDX_W-1:0]   rom_addr_q;
  logic                      wr_valid_q;
  logic [REG_W-1:0]          wr_reg_q;
  logic [REG_W-1:0]          wr_data_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic [IDX_W-1:0]          err_idx_q;
  logic [IDX_W:0]            count_q;

  logic [REG_W-1:0]          rom_reg;
  logic [REG_W-1:0]          rom_dat;
  logic [IDX_W-1:0]          idx_d;
  logic [CW-1:0]             dly_d;

  // Split the ROM word and precompute the next index and the delay load value.
  assign rom_reg = i_rom_data[2*REG_W-1:REG_W];
  assign rom_dat = i_rom_data[REG_W-1:0];
  assign idx_d   = idx_q + 1'b1;
  assign dly_d   = CW'(rom_dat) * DU_C;

  // Sequencer FSM. All outputs are registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      prof_q     <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      dly_q      <= '0;
      rom_addr_q <= '0;
      wr_valid_q <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      count_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            prof_q     <= i_profile;
            idx_q      <= '0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            count_q    <= '0;
            busy_q     <= 1'b1;
            rom_addr_q <= {i_profile, {IDX_W{1'b0}}};
            state_q    <= S_FETCH;
          end
        end
        S_FETCH:    state_q <= S_ROM_WAIT;
        S_ROM_WAIT: state_q <= S_DECODE;
        S_DECODE: begin
          if (rom_reg == MARK) begin
            if (rom_dat == MARK) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dly_q   <= dly_d;
              state_q <= S_DELAY;
            end
          end else begin
            wr_reg_q   <= rom_reg;
            wr_data_q  <= rom_dat;
            retry_q    <= '0;
            wr_valid_q <= 1'b1;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_wr_ready) begin
            wr_valid_q <= 1'b0;
            state_q    <= S_ACK;
          end
        end
        S_ACK: begin
          if (i_wr_done) begin
            if (!i_wr_nack) begin
              count_q <= count_q + 1'b1;
              state_q <= S_NEXT;
            end else if (retry_q < RETRY_MAX) begin
              retry_q    <= retry_q + 1'b1;
              wr_valid_q <= 1'b1;
              state_q    <= S_REQ;
            end else begin
              err_q     <= 1'b1;
              err_idx_q <= idx_q;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        S_DELAY: begin
          if (dly_q == '0) state_q <= S_NEXT;
          else             dly_q   <= dly_q - 1'b1;
        end
        S_NEXT: begin
          // The last index is an implicit end of table. The index never wraps.
          if (idx_q == '1) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q      <= idx_d;
            rom_addr_q <= {prof_q, idx_d};
            state_q    <= S_FETCH;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_reg   = wr_reg_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_err_idx  = err_idx_q;
  assign o_count    = count_q;

endmodule
